// File: rtl/uart_pkg.sv
// Shared UART transmit definitions: FSM states, data width and frame-length helpers.
// Purely declarative; no logic, no latency, no flow control.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;
  // Start bit plus data bits; stop and optional parity bits are added per build.
  localparam int UART_FRAME_CORE = 1 + UART_DATA_BITS;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_tx_state_e;

  function automatic int uart_frame_len(input int stop_bits, input bit parity_en);
    return UART_FRAME_CORE + stop_bits + (parity_en ? 1 : 0);
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO for the UART transmitter; head entry visible combinationally, push/pop take effect on the edge.
// Pushes while full and pops while empty are ignored; full/empty are derived only from the registered count.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           push_i,
  input  logic [WIDTH-1:0]               push_dat_i,
  input  logic                           pop_i,
  output logic [WIDTH-1:0]               head_dat_o,
  output logic                           full_o,
  output logic                           empty_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full_o     = (count_q == CW'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign head_dat_o = mem_q[rd_ptr_q];
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;

  // Depth is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1/8N2 UART transmitter (optional parity via UART_TX_PARITY_EN): start bit appears one edge after a byte is queued idle.
// tx_ready drops only when the FIFO holds FIFO_DEPTH bytes; frames run back-to-back while bytes are queued.
module uart_tx #(
  parameter int FIFO_DEPTH = 4,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                               baud_clk,
  input  logic                               reset,
  input  logic [7:0]                         tx_data,
  input  logic                               tx_valid,
  output logic                               tx_ready,
  output logic                               tx_out,
  output logic                               tx_busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);

  import uart_pkg::*;

  localparam logic STOP_LAST = (STOP_BITS == 2);

  uart_tx_state_e state_q, state_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]                bit_q, bit_d;
  logic                      stop_q, stop_d;
  logic                      tx_out_q, tx_out_d;
`ifdef UART_TX_PARITY_EN
  logic                      par_q, par_d;
`endif

  logic                      fifo_full, fifo_empty, pop;
  logic                      frame_end;
  logic [UART_DATA_BITS-1:0] head_dat;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .clk_i      (baud_clk),
    .rst_i      (reset),
    .push_i     (tx_valid && tx_ready),
    .push_dat_i (tx_data),
    .pop_i      (pop),
    .head_dat_o (head_dat),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
  );

  assign tx_ready = !fifo_full;
  assign tx_out   = tx_out_q;
  assign tx_busy  = (state_q != ST_IDLE) || !fifo_empty;

  // A new frame may start from idle or on the final stop cycle, giving gapless back-to-back frames.
  assign frame_end = (state_q == ST_IDLE) || ((state_q == ST_STOP) && (stop_q == STOP_LAST));
  assign pop       = frame_end && !fifo_empty;

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bit_d    = bit_q;
    stop_d   = stop_q;
    tx_out_d = tx_out_q;
`ifdef UART_TX_PARITY_EN
    par_d    = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        tx_out_d = 1'b1;
      end
      ST_START: begin
        tx_out_d = shift_q[0];
        shift_d  = shift_q >> 1;
        bit_d    = 3'd0;
        state_d  = ST_DATA;
      end
      ST_DATA: begin
        if (bit_q == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
          tx_out_d = par_q;
          state_d  = ST_PARITY;
`else
          tx_out_d = 1'b1;
          stop_d   = 1'b0;
          state_d  = ST_STOP;
`endif
        end else begin
          tx_out_d = shift_q[0];
          shift_d  = shift_q >> 1;
          bit_d    = bit_q + 3'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        tx_out_d = 1'b1;
        stop_d   = 1'b0;
        state_d  = ST_STOP;
      end
`endif
      ST_STOP: begin
        tx_out_d = 1'b1;
        if (stop_q == STOP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          stop_d = 1'b1;
        end
      end
      default: begin
        tx_out_d = 1'b1;
        state_d  = ST_IDLE;
      end
    endcase

    if (pop) begin
      shift_d  = head_dat;
      tx_out_d = 1'b0;
      state_d  = ST_START;
`ifdef UART_TX_PARITY_EN
      par_d    = (^head_dat) ^ 1'(PARITY_ODD);
`endif
    end
  end

  always_ff @(posedge baud_clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      shift_q  <= '0;
      bit_q    <= '0;
      stop_q   <= 1'b0;
      tx_out_q <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bit_q    <= bit_d;
      stop_q   <= stop_d;
      tx_out_q <= tx_out_d;
`ifdef UART_TX_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Byte-serial UART transmitter: the transmit counterpart of the team's `Uart_rx`, driven by the same `baud_clk` at one line bit per clock. It accepts bytes through a valid/ready handshake into a small FIFO. It serialises them as 8N1 frames, LSB first, back-to-back with no idle gap while data is queued. It sits between the system-side producer and the TX pin, and its output is directly consumable by `Uart_rx`.

## Interface
- `FIFO_DEPTH`, 4: transmit FIFO entries; power of two, ≥2.
- `STOP_BITS`, 1: stop bits per frame; 1 or 2.
- `PARITY_ODD`, 0: parity sense, 0 = even, 1 = odd; only used when `UART_TX_PARITY_EN` is defined.
- `baud_clk`  in  1  bit clock; one line bit per cycle, all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `tx_data`  in  8  byte to send.
- `tx_valid`  in  1  `tx_data` is valid.
- `tx_ready`  out  1  FIFO can accept a byte; the transfer occurs on a rising edge where `tx_valid && tx_ready`.
- `tx_out`  out  1  serial line, idle high, registered.
- `tx_busy`  out  1  frame in progress or FIFO non-empty.
- `fifo_count`  out  $clog2(FIFO_DEPTH+1)  bytes queued, excluding the frame in flight.

## Operation
- FSM states:
  - IDLE: line high.
  - START: one cycle, line 0.
  - DATA: 8 cycles, bits 0..7.
  - PARITY: one cycle; exists only when `UART_TX_PARITY_EN` is defined.
  - STOP: `STOP_BITS` cycles, line 1.
- IDLE → START when the FIFO is non-empty. On that edge, pop the head into the shift register and drive `tx_out` to 0.
- DATA:
  - `tx_out` = shift[0]; shift right each cycle.
  - A 3-bit counter terminates the state after bit 7.
  - Exit goes to PARITY if enabled, otherwise STOP.
- Last STOP cycle:
  - FIFO non-empty → pop and go directly to START. The next start bit immediately follows the stop bit.
  - FIFO empty → IDLE.
- FIFO:
  - `tx_ready = (fifo_count != FIFO_DEPTH)`. It depends only on count, never on a same-cycle pop.
  - Simultaneous push and pop leaves the count unchanged; the pushed byte goes behind the existing contents.
  - Read and write pointers wrap modulo `FIFO_DEPTH`.
- A write while `tx_ready` = 0 is ignored; the producer must hold `tx_valid` and `tx_data`.
- `tx_data` is captured at acceptance; later changes do not affect queued bytes.
- `tx_busy = (state != IDLE) || (fifo_count != 0)`.

## Timing
- Reset values, applied on the next rising edge with `reset` high:
  - `tx_out` = 1, state = IDLE.
  - FIFO flushed: `fifo_count` = 0, `tx_ready` = 1, `tx_busy` = 0.
  - Shift register and counters cleared.
- Reset mid-frame truncates the frame: the line returns high on that edge and queued bytes are discarded.
- Latency: a byte accepted at edge N while idle and empty produces the start bit on `tx_out` after edge N+1.
  - Data bit k follows edge N+2+k.
  - Stop bit follows edge N+10, or N+11 with parity.
- Frame length:
  - 9 + `STOP_BITS` cycles.
  - 10 + `STOP_BITS` cycles with parity.
- Throughput: one frame per frame length while the FIFO is non-empty; no gap cycles.

## Configuration
- `UART_TX_PARITY_EN`:
  - Defined: PARITY state inserted after bit 7, driving the XOR of the 8 data bits XOR `PARITY_ODD`.
  - Undefined: PARITY state, parity logic and `PARITY_ODD` usage are compiled out; frame is 8N1/8N2.

## Structure
- Package `uart_pkg`: FSM state enum, `UART_DATA_BITS` = 8, and the frame-length constants.
- Sub-module `uart_tx_fifo`: synchronous FIFO, parameterised depth and width, with push/pop/full/empty/count.
- `uart_tx` holds the FSM, shift register, bit counter and parity.

## Test plan
- Idle, send 0xA5 → `tx_out` over 10 cycles from edge N+1: 0,1,0,1,0,0,1,0,1,1; `tx_busy` then low, line held high.
- Push 0xA5, 0xC3, 0xD5 on consecutive cycles → 30 contiguous frame cycles with no idle gap; a `Uart_rx` instance on `tx_out` reports A5, C3, D5.
- Hold `tx_valid` for 8 consecutive cycles with `FIFO_DEPTH` = 4 → 5 bytes accepted (the first is popped immediately) and `tx_ready` low after the 5th. `tx_ready` reasserts on the edge the next frame pops, and all bytes arrive in order.
- With `UART_TX_PARITY_EN` defined, send 0xA5 → parity bit 0 for `PARITY_ODD` = 0 and 1 for `PARITY_ODD` = 1; frame is 11 cycles.
- Assert `reset` for one cycle during data bit 3 with 2 bytes queued → `tx_out` = 1 next edge, `fifo_count` = 0, `tx_busy` = 0, no further frames.
- `STOP_BITS` = 2, two back-to-back bytes → exactly 2 high cycles between the last data bit and the next start bit.
